tea_dec_iter: RTL and testbench

Iterative TEA decryption engine. It is the receive-side counterpart of the combinational full_encryptor. It accepts one 64-bit ciphertext block and a 128-bit key through a valid/ready handshake, runs one full TEA decryption round per enabled clock, and presents the plaintext through an output valid/ready handshake. It replaces the unrolled full_decryptor wherever area matters more than throughput.

---
 rtl/tea_pkg.sv | 35 +++
 rtl/tea_dec_iter_if.sv | 32 +++
 rtl/tea_dec_round.sv | 31 +++
 rtl/tea_dec_iter.sv | 115 +++++++++++
 tb/tb_tea_dec_iter.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared TEA constants, key-word helpers and FSM state type
package tea_pkg;

    localparam logic [31:0] TEA_DELTA          = 32'h9e37_79b9;
    localparam int unsigned TEA_ROUNDS_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tea_state_e;

    // Decryption walks the key schedule backwards from the sum the encryptor ended on.
    function automatic logic [31:0] tea_init_sum(input logic [31:0] delta,
                                                 input int unsigned rounds);
        return delta * 32'(rounds);
    endfunction

    function automatic logic [31:0] tea_k0(input logic [127:0] key);
        return key[127:96];
    endfunction

    function automatic logic [31:0] tea_k1(input logic [127:0] key);
        return key[95:64];
    endfunction

    function automatic logic [31:0] tea_k2(input logic [127:0] key);
        return key[63:32];
    endfunction

    function automatic logic [31:0] tea_k3(input logic [127:0] key);
        return key[31:0];
    endfunction

endpackage

// File: rtl/tea_dec_iter_if.sv
// rtl/tea_dec_iter_if.sv - block input and plaintext output handshakes of the decryptor
interface tea_dec_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic [63:0]  inBlock64;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  outBlock64;

    modport master (
        output in_valid,
        output inBlock64,
        output key,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  outBlock64
    );

    modport slave (
        input  in_valid,
        input  inBlock64,
        input  key,
        input  out_ready,
        output in_ready,
        output out_valid,
        output outBlock64
    );

endinterface

// File: rtl/tea_dec_round.sv
// rtl/tea_dec_round.sv - one combinational TEA decryption cycle (v1 first, then v0 from the new v1)
module tea_dec_round
    import tea_pkg::*;
(
    input  logic [31:0]  v0_i,
    input  logic [31:0]  v1_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    output logic [31:0]  v0_o,
    output logic [31:0]  v1_o
);

    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
    logic [31:0] mix1;
    logic [31:0] mix0;

    assign k0 = tea_k0(key_i);
    assign k1 = tea_k1(key_i);
    assign k2 = tea_k2(key_i);
    assign k3 = tea_k3(key_i);

    assign mix1 = ((v0_i << 4) + k2) ^ (v0_i + sum_i) ^ ((v0_i >> 5) + k3);
    assign v1_o = v1_i - mix1;

    assign mix0 = ((v1_o << 4) + k0) ^ (v1_o + sum_i) ^ ((v1_o >> 5) + k1);
    assign v0_o = v0_i - mix0;

endmodule

// File: rtl/tea_dec_iter.sv
// rtl/tea_dec_iter.sv - iterative TEA decryptor, one round per enabled clock
module tea_dec_iter
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS = TEA_ROUNDS_DEFAULT,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    output logic          busy,
    tea_dec_iter_if.slave bus
);

    localparam int               CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);
    localparam logic [31:0]      SUM_INIT = tea_init_sum(DELTA, ROUNDS);

    tea_state_e         state_q, state_d;
    logic [31:0]        v0_q, v0_d;
    logic [31:0]        v1_q, v1_d;
    logic [31:0]        sum_q, sum_d;
    logic [127:0]       key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        out_block_q, out_block_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [31:0]        rnd_v0;
    logic [31:0]        rnd_v1;

    tea_dec_round u_round (
        .v0_i  (v0_q),
        .v1_i  (v1_q),
        .sum_i (sum_q),
        .key_i (key_q),
        .v0_o  (rnd_v0),
        .v1_o  (rnd_v1)
    );

    always_comb begin
        state_d     = state_q;
        v0_d        = v0_q;
        v1_d        = v1_q;
        sum_d       = sum_q;
        key_d       = key_q;
        cnt_d       = cnt_q;
        out_block_d = out_block_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    v0_d    = bus.inBlock64[63:32];
                    v1_d    = bus.inBlock64[31:0];
                    key_d   = bus.key;
                    sum_d   = SUM_INIT;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                v0_d  = rnd_v0;
                v1_d  = rnd_v1;
                sum_d = sum_q - DELTA;
                cnt_d = cnt_q + CNT_W'(1);
                // The plaintext is captured separately so it survives the next accept.
                if (cnt_q == CNT_LAST) begin
                    out_block_d = {rnd_v0, rnd_v1};
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            v0_q        <= '0;
            v1_q        <= '0;
            sum_q       <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            out_block_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            sum_q       <= sum_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            out_block_q <= out_block_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.outBlock64 = out_block_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_tea_dec_iter.sv
// tb/tb_tea_dec_iter.sv - directed bench for the iterative TEA decryptor (32- and 1-round builds)
module tb_tea_dec_iter;

    logic clk;
    logic rst;
    logic ena;
    logic busy;
    logic busy1;

    int checks;
    int errors;

    tea_dec_iter_if bus();
    tea_dec_iter_if bus1();

    tea_dec_iter u_dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .busy (busy),
        .bus  (bus)
    );

    tea_dec_iter #(.ROUNDS(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .busy (busy1),
        .bus  (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference encryptor; the DUT must invert it.
    function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] k,
                                            input int rounds);
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] s;
        v0 = pt[63:32];
        v1 = pt[31:0];
        s  = 32'h0;
        for (int i = 0; i < rounds; i++) begin
            s  = s + 32'h9e37_79b9;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    task automatic send(input logic [63:0] blk, input logic [127:0] k);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid  = 1'b1;
        bus.inBlock64 = blk;
        bus.key       = k;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.inBlock64 = {$urandom, $urandom};
        bus.key       = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out(input int limit, output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < limit) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            bus.outBlock64 !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, busy, bus.outBlock64);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known_vector;
        int lat;
        int busy_n;
        send(64'h41EA3A0A_94BAA940, 128'h0);
        lat    = 0;
        busy_n = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 32) begin
            errors++;
            $display("FAIL kv_latency: got %0d edges, want 32", lat);
        end
        checks++;
        if (busy_n !== 32) begin
            errors++;
            $display("FAIL kv_busy_cycles: got %0d, want 32", busy_n);
        end
        checks++;
        if (bus.outBlock64 !== 64'h0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL kv_result: out=%h busy=%b in_ready=%b, want 0 0 0",
                     bus.outBlock64, busy, bus.in_ready);
        end
        handoff();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.outBlock64 !== 64'h0) begin
            errors++;
            $display("FAIL kv_handoff: out_valid=%b in_ready=%b out=%h, want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.outBlock64);
        end
    endtask

    task automatic test_round_trip;
        logic [63:0]  pt;
        logic [127:0] k;
        int lat;
        int hold;
        for (int i = 0; i < 200; i++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            send(tea_enc(pt, k, 32), k);
            wait_out(100, lat);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.outBlock64 !== pt) begin
                errors++;
                $display("FAIL round_trip[%0d]: out_valid=%b out=%h, want 1 %h",
                         i, bus.out_valid, bus.outBlock64, pt);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            if (hold > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.outBlock64 !== pt) begin
                    errors++;
                    $display("FAIL backpressure[%0d]: out_valid=%b out=%h, want 1 %h",
                             i, bus.out_valid, bus.outBlock64, pt);
                end
            end
            handoff();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.outBlock64 !== pt) begin
            errors++;
            $display("FAIL out_hold_after_handoff: out_valid=%b out=%h, want 0 %h",
                     bus.out_valid, bus.outBlock64, pt);
        end
    endtask

    task automatic test_ena_toggle;
        logic [63:0]  pt;
        logic [127:0] k;
        int lat;
        int lows;
        int highs;
        pt = 64'h0123_4567_89ab_cdef;
        k  = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
        send(tea_enc(pt, k, 32), k);
        lat   = 0;
        lows  = 0;
        highs = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (lows < 10 && (highs >= 20 || $urandom_range(0, 2) != 0)) begin
                ena = 1'b0;
                lows++;
            end else begin
                ena = 1'b1;
                highs++;
            end
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1;
        checks++;
        if (lat !== 42) begin
            errors++;
            $display("FAIL ena_latency: got %0d edges, want 42", lat);
        end
        checks++;
        if (bus.outBlock64 !== pt) begin
            errors++;
            $display("FAIL ena_result: got %h, want %h", bus.outBlock64, pt);
        end
        ena           = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.outBlock64 !== pt) begin
            errors++;
            $display("FAIL ena_low_no_handoff: out_valid=%b out=%h, want 1 %h",
                     bus.out_valid, bus.outBlock64, pt);
        end
        ena = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ena_high_handoff: out_valid=%b in_ready=%b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        ena          = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ena_low_no_accept: busy=%b in_ready=%b, want 0 1", busy, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        ena          = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [63:0]  pt;
        logic [127:0] k;
        int lat;
        pt = 64'hfeed_face_0bad_f00d;
        k  = 128'h1357_9bdf_2468_ace0_0f1e_2d3c_4b5a_6978;
        bus.inBlock64 = tea_enc(pt, k, 32);
        bus.key       = k;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_accept: busy=%b in_ready=%b, want 1 0", busy, bus.in_ready);
        end
        wait_out(100, lat);
        checks++;
        if (lat !== 32 || bus.outBlock64 !== pt) begin
            errors++;
            $display("FAIL b2b_first_result: lat=%0d out=%h, want 32 %h", lat, bus.outBlock64, pt);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                     bus.out_valid, bus.in_ready, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b, want 1", busy);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        wait_out(100, lat);
        checks++;
        if (lat !== 32 || bus.outBlock64 !== pt) begin
            errors++;
            $display("FAIL b2b_second_result: lat=%0d out=%h, want 32 %h", lat, bus.outBlock64, pt);
        end
        handoff();
    endtask

    task automatic test_reset_mid;
        logic [63:0]  pt;
        logic [127:0] k;
        int lat;
        pt = 64'h5555_aaaa_3333_cccc;
        k  = 128'hdead_beef_0123_4567_89ab_cdef_f0e1_d2c3;
        send(tea_enc(pt, k, 32), k);
        repeat (17) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.outBlock64 !== 64'h0 || busy !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: out_valid=%b out=%h busy=%b in_ready=%b, want 0 0 0 1",
                     bus.out_valid, bus.outBlock64, busy, bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        pt = 64'h0f0f_0f0f_f0f0_f0f0;
        send(tea_enc(pt, k, 32), k);
        wait_out(100, lat);
        checks++;
        if (lat !== 32 || bus.outBlock64 !== pt) begin
            errors++;
            $display("FAIL reset_mid_next: lat=%0d out=%h, want 32 %h", lat, bus.outBlock64, pt);
        end
        handoff();
    endtask

    task automatic test_rounds1;
        logic [63:0]  pt;
        logic [127:0] k;
        for (int i = 0; i < 3; i++) begin
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            bus1.inBlock64 = tea_enc(pt, k, 1);
            bus1.key       = k;
            bus1.in_valid  = 1'b1;
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            checks++;
            if (busy1 !== 1'b1 || bus1.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL r1_run[%0d]: busy=%b out_valid=%b, want 1 0", i, busy1, bus1.out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (bus1.out_valid !== 1'b1 || bus1.outBlock64 !== pt) begin
                errors++;
                $display("FAIL r1_result[%0d]: out_valid=%b out=%h, want 1 %h",
                         i, bus1.out_valid, bus1.outBlock64, pt);
            end
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
        end
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL r1_handoff: out_valid=%b in_ready=%b, want 0 1", bus1.out_valid, bus1.in_ready);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        ena            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.inBlock64  = 64'h0;
        bus.key        = 128'h0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.inBlock64 = 64'h0;
        bus1.key       = 128'h0;
        bus1.out_ready = 1'b0;
        #2;
        test_reset();
        test_known_vector();
        test_round_trip();
        test_ena_toggle();
        test_back_to_back();
        test_reset_mid();
        test_rounds1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
